camera_reg_arbiter: RTL and testbench
=====================================

Name: camera_reg_arbiter

Overview:
Shares the single camera I2C register-write controller between two requesters. Port 0 is the power-up/config sequencer; port 1 is runtime updates such as exposure, gains and blanking from the host or an auto-exposure loop. The block arbitrates round-robin, frames each write as {SLAVE_ADDR, sub-address, data}, drives the controller's GO/END/ACK handshake, and retries NACKed writes. It also aborts hung transfers on timeout and reports completion and error per port.

Parameters:
SLAVE_ADDR, 8'hBA, camera I2C write address placed in i2c_data[31:24]
MAX_RETRY, 3, extra attempts after a NACK before reporting an error (0 = no retry)
TIMEOUT_CYCLES, 4096, clock cycles allowed from GO to END before abort (max 65535)

Ports:
clock  in  1  single clock, shared with the I2C controller work clock
reset_n  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 write request; held until req0_done
req0_addr  in  8  port 0 register sub-address
req0_data  in  16  port 0 register value
req0_done  out  1  one-cycle pulse when the port 0 transaction finishes
req0_error  out  1  valid with req0_done; 1 = NACK after retries, or timeout
req1_valid, req1_addr, req1_data, req1_done, req1_error  same as port 0, for port 1
i2c_data  out  32  {SLAVE_ADDR, addr, data} to the I2C controller
i2c_go  out  1  start-transfer level to the controller
i2c_end  in  1  controller transfer finished
i2c_ack  in  1  controller ACK flag; 0 = slave acknowledged, 1 = NACK
busy  out  1  high in any state except IDLE
grant  out  1  index of the port owning the current or last transaction
error_count  out  8  total failed transactions, saturates at 255

Behaviour:
- Reset values: all outputs 0. Internal last_grant = 1, so port 0 wins the first tie. Retry counter, timeout counter and state are cleared; state = IDLE.
- Reset mid-transaction: i2c_go drops asynchronously. The transaction is abandoned and no done pulse is issued.
- States: IDLE, ISSUE, WAIT_LOW, DONE.
- IDLE:
  - Requests are sampled here only.
  - One valid: grant that port.
  - Both valid: grant the port != last_grant.
  - On grant, in the same edge: latch i2c_data = {SLAVE_ADDR, addr, data}, set grant, clear retry and timeout counters, i2c_go <= 1, go to ISSUE.
  - i2c_data holds its value outside transactions.
- ISSUE: i2c_go stays high; the timeout counter increments every cycle.
  - i2c_end=1 and i2c_ack=0: i2c_go <= 0, success, go to DONE.
  - i2c_end=1, i2c_ack=1, retry < MAX_RETRY: i2c_go <= 0, retry++, go to WAIT_LOW.
  - i2c_end=1, i2c_ack=1, retry == MAX_RETRY: i2c_go <= 0, error, go to DONE.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with i2c_end=0: i2c_go <= 0, error, go to DONE. END wins if both occur in the same cycle.
- WAIT_LOW:
  - Stay while i2c_end=1.
  - When i2c_end=0: i2c_go <= 1, clear the timeout counter, return to ISSUE. The same i2c_data is resent.
  - There is no timeout in this state.
- DONE (one cycle):
  - reqN_done = 1 for the granted port only; reqN_error = error flag.
  - last_grant <= grant.
  - error_count increments on error, saturating at 255.
  - Go to IDLE.
- Latency: i2c_go rises 1 cycle after valid is seen in IDLE. done pulses 1 cycle after the accepting i2c_end. Minimum request-to-done is 3 cycles plus the controller time.
- Requester rule: deassert valid on the edge that samples done=1. Valid still high in the following IDLE cycle is a new request.
- Changes to valid, addr or data during a transaction are ignored; the latched values are used.
- Fairness: a continuously valid port cannot be granted twice in a row while the other port is valid.
- i2c_go is never high in IDLE or DONE.

Test Plan:
- Single write, port 0, addr 8'h09, data 16'h0400, controller ACKs after 10 cycles -> i2c_data = 32'hBA090400; i2c_go high for 10 cycles; req0_done pulse with req0_error=0; error_count = 0.
- Both valid in the same cycle from reset (p0 addr 8'h2B, p1 addr 8'h05) -> port 0 served first, then port 1. With both held continuously for 4 transactions, the grant order is 0,1,0,1.
- Port 1 gets NACK twice then ACK, MAX_RETRY=3 -> three GO pulses, each re-asserted only after i2c_end drops; req1_done with req1_error=0.
- Persistent NACK, MAX_RETRY=3 -> exactly 4 GO pulses, then req0_done with req0_error=1; error_count = 1.
- i2c_end never asserts, TIMEOUT_CYCLES=16 -> i2c_go falls after 16 cycles; done with error=1.
- reset_n asserted while in ISSUE -> i2c_go=0, busy=0 immediately; no done pulse. After release, a pending valid restarts from IDLE with port 0 priority.

Source files
------------

// File: rtl/camera_reg_arbiter.sv
// rtl/camera_reg_arbiter.sv - two-port round-robin arbiter for the camera I2C register-write controller
module camera_reg_arbiter #(
   parameter logic [7:0] SLAVE_ADDR     = 8'hBA,
   parameter int         MAX_RETRY      = 3,
   parameter int         TIMEOUT_CYCLES = 4096
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_addr,
   input  logic [15:0] req0_data,
   output logic        req0_done,
   output logic        req0_error,
   input  logic        req1_valid,
   input  logic [7:0]  req1_addr,
   input  logic [15:0] req1_data,
   output logic        req1_done,
   output logic        req1_error,
   output logic [31:0] i2c_data,
   output logic        i2c_go,
   input  logic        i2c_end,
   input  logic        i2c_ack,
   output logic        busy,
   output logic        grant,
   output logic [7:0]  error_count
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_LOW = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_last_grant;
   logic            r_grant;
   logic            r_error;
   logic [RW-1:0]   r_retry;
   logic [15:0]     r_timeout;
   logic [31:0]     r_data;
   logic [7:0]      r_err_cnt;

   logic            w_accept;
   logic            w_pick;
   logic            w_retry;
   logic            w_fail;

   // Next-state decode: arbitration in IDLE, END/ACK/timeout resolution in ISSUE
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_pick       = 1'b0;
      w_retry      = 1'b0;
      w_fail       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req0_valid && req1_valid) begin
               w_accept = 1'b1;
               w_pick   = ~r_last_grant;
            end else if (req0_valid) begin
               w_accept = 1'b1;
               w_pick   = 1'b0;
            end else if (req1_valid) begin
               w_accept = 1'b1;
               w_pick   = 1'b1;
            end
            if (w_accept) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // END takes priority over a timeout landing in the same cycle
            if (i2c_end) begin
               if (!i2c_ack) begin
                  w_state_next = ST_DONE;
               end else if (r_retry != RETRY_MAX) begin
                  w_retry      = 1'b1;
                  w_state_next = ST_WAIT_LOW;
               end else begin
                  w_fail       = 1'b1;
                  w_state_next = ST_DONE;
               end
            end else if (r_timeout == TO_LAST) begin
               w_fail       = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_WAIT_LOW: begin
            if (!i2c_end) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register; reset returns to IDLE so GO drops without waiting for a clock
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Transaction datapath: latched frame, owner, retry/timeout counters, error tally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_error      <= 1'b0;
         r_retry      <= '0;
         r_timeout    <= '0;
         r_data       <= '0;
         r_err_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_data    <= w_pick ? {SLAVE_ADDR, req1_addr, req1_data}
                                : {SLAVE_ADDR, req0_addr, req0_data};
            r_grant   <= w_pick;
            r_retry   <= '0;
            r_timeout <= '0;
            r_error   <= 1'b0;
         end
         if (r_state == ST_ISSUE) begin
            r_timeout <= r_timeout + 16'd1;
         end
         if (w_retry) begin
            r_retry <= r_retry + RW'(1);
         end
         if (w_fail) begin
            r_error <= 1'b1;
         end
         if ((r_state == ST_WAIT_LOW) && !i2c_end) begin
            r_timeout <= '0;
         end
         if (r_state == ST_DONE) begin
            r_last_grant <= r_grant;
            if (r_error && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
      end
   end

   assign i2c_go      = (r_state == ST_ISSUE);
   assign busy        = (r_state != ST_IDLE);
   assign req0_done   = (r_state == ST_DONE) && !r_grant;
   assign req1_done   = (r_state == ST_DONE) &&  r_grant;
   assign req0_error  = req0_done && r_error;
   assign req1_error  = req1_done && r_error;
   assign i2c_data    = r_data;
   assign grant       = r_grant;
   assign error_count = r_err_cnt;

endmodule

// File: tb/tb_camera_reg_arbiter.sv
// tb/tb_camera_reg_arbiter.sv - scoreboard bench for camera_reg_arbiter with a behavioural I2C controller
module tb_camera_reg_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid = 1'b0;
   logic [7:0]  req0_addr = '0;
   logic [15:0] req0_data = '0;
   logic        req1_valid = 1'b0;
   logic [7:0]  req1_addr = '0;
   logic [15:0] req1_data = '0;
   logic        i2c_end = 1'b0;
   logic        i2c_ack = 1'b0;
   logic        req0_done, req0_error, req1_done, req1_error;
   logic [31:0] i2c_data;
   logic        i2c_go, busy, grant;
   logic [7:0]  error_count;

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard entry: {port, error, i2c_data}
   logic [33:0] sb[$];

   int go_pulses   = 0;
   int go_len      = 0;
   int last_go_len = 0;
   int done_count  = 0;
   int inv_err     = 0;
   int r0_left     = 0;
   int r1_left     = 0;
   int ctl_delay   = 3;
   int ctl_nacks   = 0;
   int ctl_cnt     = 0;
   bit ctl_hang    = 1'b0;
   bit prev_go     = 1'b0;

   camera_reg_arbiter #(
      .SLAVE_ADDR     (8'hBA),
      .MAX_RETRY      (3),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req0_done   (req0_done),
      .req0_error  (req0_error),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .req1_done   (req1_done),
      .req1_error  (req1_error),
      .i2c_data    (i2c_data),
      .i2c_go      (i2c_go),
      .i2c_end     (i2c_end),
      .i2c_ack     (i2c_ack),
      .busy        (busy),
      .grant       (grant),
      .error_count (error_count)
   );

   always #5 clock = ~clock;

   // Monitor, scoreboard, requester release and controller model, all at the falling edge
   initial begin
      logic [33:0] got;
      logic [33:0] exp;
      forever begin
         @(negedge clock);
         if (i2c_go && (!busy || req0_done || req1_done)) inv_err++;
         if (req0_done && req1_done) inv_err++;
         if (i2c_go && !prev_go) begin
            go_pulses++;
            go_len = 0;
            if (i2c_end) inv_err++;
         end
         if (i2c_go) go_len++;
         else if (prev_go) last_go_len = go_len;
         prev_go = i2c_go;

         if (req0_done || req1_done) begin
            done_count++;
            got = {req1_done, (req1_done ? req1_error : req0_error), i2c_data};
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected_done: got %h expected no completion", got);
            end else begin
               exp = sb.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL sb_done: got port/err/data %h expected %h", got, exp);
               end
            end
            if (req0_done) begin
               if (r0_left > 0) r0_left--;
               if (r0_left == 0) req0_valid = 1'b0;
            end
            if (req1_done) begin
               if (r1_left > 0) r1_left--;
               if (r1_left == 0) req1_valid = 1'b0;
            end
         end

         if (i2c_go && !i2c_end) begin
            ctl_cnt++;
            if (!ctl_hang && ctl_cnt == ctl_delay) begin
               i2c_end = 1'b1;
               if (ctl_nacks > 0) begin
                  i2c_ack = 1'b1;
                  ctl_nacks--;
               end else begin
                  i2c_ack = 1'b0;
               end
            end
         end else if (!i2c_go) begin
            i2c_end = 1'b0;
            i2c_ack = 1'b0;
            ctl_cnt = 0;
         end
      end
   end

   task test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      n_tests++;
      if ({i2c_data, i2c_go, busy, grant, error_count, req0_done, req0_error, req1_done, req1_error} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h go=%b busy=%b grant=%b ec=%0d expected all zero",
                  i2c_data, i2c_go, busy, grant, error_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      n_tests++;
      if (busy !== 1'b0 || i2c_go !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b go=%b expected 0 0", busy, i2c_go);
      end
   endtask

   task test_round_robin;
      int target;
      target = done_count + 4;
      ctl_delay = 3;
      @(negedge clock);
      req0_addr = 8'h2B; req0_data = 16'h1111;
      req1_addr = 8'h05; req1_data = 16'h2222;
      r0_left = 2; r1_left = 2;
      sb.push_back({1'b0, 1'b0, 32'hBA2B1111});
      sb.push_back({1'b1, 1'b0, 32'hBA052222});
      sb.push_back({1'b0, 1'b0, 32'hBA2B1111});
      sb.push_back({1'b1, 1'b0, 32'hBA052222});
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 200 && done_count < target; i++) @(negedge clock);
      n_tests++;
      if (done_count != target) begin
         n_fail++;
         $display("FAIL rr_timeout: got %0d completions expected %0d", done_count, target);
      end
      @(negedge clock);
   endtask

   task test_single_write;
      int target, p0;
      target = done_count + 1;
      p0 = go_pulses;
      ctl_delay = 10;
      @(negedge clock);
      req0_addr = 8'h09; req0_data = 16'h0400; r0_left = 1;
      sb.push_back({1'b0, 1'b0, 32'hBA090400});
      req0_valid = 1'b1;
      for (int i = 0; i < 100 && done_count < target; i++) @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (done_count != target) begin
         n_fail++;
         $display("FAIL single_timeout: got %0d completions expected %0d", done_count, target);
      end
      n_tests++;
      if (last_go_len != 10 || go_pulses - p0 != 1) begin
         n_fail++;
         $display("FAIL single_go: got len=%0d pulses=%0d expected len=10 pulses=1", last_go_len, go_pulses - p0);
      end
      n_tests++;
      if (error_count !== 8'd0) begin
         n_fail++;
         $display("FAIL single_errcnt: got %0d expected 0", error_count);
      end
   endtask

   task test_retry;
      int target, p0;
      target = done_count + 1;
      p0 = go_pulses;
      ctl_delay = 4; ctl_nacks = 2;
      @(negedge clock);
      req1_addr = 8'h3A; req1_data = 16'h0123; r1_left = 1;
      sb.push_back({1'b1, 1'b0, 32'hBA3A0123});
      req1_valid = 1'b1;
      for (int i = 0; i < 200 && done_count < target; i++) @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (done_count != target || go_pulses - p0 != 3) begin
         n_fail++;
         $display("FAIL retry_pulses: got done=%0d pulses=%0d expected done=%0d pulses=3",
                  done_count, go_pulses - p0, target);
      end
   endtask

   task test_nack_error;
      int target, p0;
      target = done_count + 1;
      p0 = go_pulses;
      ctl_delay = 2; ctl_nacks = 4;
      @(negedge clock);
      req0_addr = 8'h12; req0_data = 16'hBEEF; r0_left = 1;
      sb.push_back({1'b0, 1'b1, 32'hBA12BEEF});
      req0_valid = 1'b1;
      for (int i = 0; i < 200 && done_count < target; i++) @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (done_count != target || go_pulses - p0 != 4) begin
         n_fail++;
         $display("FAIL nack_pulses: got done=%0d pulses=%0d expected done=%0d pulses=4",
                  done_count, go_pulses - p0, target);
      end
      n_tests++;
      if (error_count !== 8'd1) begin
         n_fail++;
         $display("FAIL nack_errcnt: got %0d expected 1", error_count);
      end
      ctl_nacks = 0;
   endtask

   task test_timeout;
      int target;
      target = done_count + 1;
      ctl_hang = 1'b1;
      @(negedge clock);
      req1_addr = 8'h77; req1_data = 16'hA5A5; r1_left = 1;
      sb.push_back({1'b1, 1'b1, 32'hBA77A5A5});
      req1_valid = 1'b1;
      for (int i = 0; i < 100 && done_count < target; i++) @(negedge clock);
      @(negedge clock);
      ctl_hang = 1'b0;
      n_tests++;
      if (done_count != target || last_go_len != 16) begin
         n_fail++;
         $display("FAIL timeout_go: got done=%0d len=%0d expected done=%0d len=16", done_count, last_go_len, target);
      end
      n_tests++;
      if (error_count !== 8'd2) begin
         n_fail++;
         $display("FAIL timeout_errcnt: got %0d expected 2", error_count);
      end
   endtask

   task test_reset_mid;
      int start;
      ctl_hang = 1'b1;
      @(negedge clock);
      req1_addr = 8'h44; req1_data = 16'h5555; r1_left = 1;
      req1_valid = 1'b1;
      for (int i = 0; i < 10 && !i2c_go; i++) @(negedge clock);
      n_tests++;
      if (i2c_go !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_issue: got go=%b expected 1", i2c_go);
      end
      repeat (3) @(negedge clock);
      start = done_count;
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (i2c_go !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got go=%b busy=%b expected 0 0", i2c_go, busy);
      end
      n_tests++;
      if (error_count !== 8'd0) begin
         n_fail++;
         $display("FAIL rstmid_errcnt: got %0d expected 0", error_count);
      end
      req1_valid = 1'b0; r1_left = 0; ctl_hang = 1'b0; ctl_delay = 3;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      n_tests++;
      if (done_count != start) begin
         n_fail++;
         $display("FAIL rstmid_nodone: got %0d completions expected %0d", done_count, start);
      end
      req0_addr = 8'h2B; req0_data = 16'h0001;
      req1_addr = 8'h05; req1_data = 16'h0002;
      r0_left = 1; r1_left = 1;
      sb.push_back({1'b0, 1'b0, 32'hBA2B0001});
      sb.push_back({1'b1, 1'b0, 32'hBA050002});
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 100 && done_count < start + 2; i++) @(negedge clock);
      @(negedge clock);
      n_tests++;
      if (done_count != start + 2) begin
         n_fail++;
         $display("FAIL rstmid_restart: got %0d completions expected %0d", done_count, start + 2);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_retry();
      test_nack_error();
      test_timeout();
      test_reset_mid();
      n_tests++;
      if (inv_err != 0) begin
         n_fail++;
         $display("FAIL go_invariants: got %0d violations expected 0", inv_err);
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
